// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data_memory block: default geometry,
// word/address typedefs and the decode of the mem_read/mem_write strobes.
package dmem_pkg;

    localparam int DMEM_ADDR_WIDTH = 8;
    localparam int DMEM_DATA_WIDTH = 16;

    typedef logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_t;
    typedef logic [DMEM_DATA_WIDTH-1:0] dmem_word_t;

    // Access kind implied by the two strobes in one cycle.
    typedef enum logic [1:0] {
        DMEM_OP_IDLE       = 2'b00,
        DMEM_OP_WRITE      = 2'b01,
        DMEM_OP_READ       = 2'b10,
        DMEM_OP_READ_WRITE = 2'b11
    } dmem_op_e;

    // Per-cycle control derived from the access kind.
    //   wr_en  : update the addressed storage word
    //   rd_en  : load the read_data register
    //   bypass : read_data takes the incoming write data (write-through)
    typedef struct packed {
        logic wr_en;
        logic rd_en;
        logic bypass;
    } dmem_ctrl_t;

    function automatic dmem_op_e dmem_decode_op(input logic mem_read,
                                                input logic mem_write);
        dmem_op_e op;
        case ({mem_read, mem_write})
            2'b01:   op = DMEM_OP_WRITE;
            2'b10:   op = DMEM_OP_READ;
            2'b11:   op = DMEM_OP_READ_WRITE;
            default: op = DMEM_OP_IDLE;
        endcase
        return op;
    endfunction

    function automatic dmem_ctrl_t dmem_op_ctrl(input dmem_op_e op);
        dmem_ctrl_t ctrl;
        ctrl = '{wr_en: 1'b0, rd_en: 1'b0, bypass: 1'b0};
        case (op)
            DMEM_OP_WRITE:      ctrl.wr_en = 1'b1;
            DMEM_OP_READ:       ctrl.rd_en = 1'b1;
            DMEM_OP_READ_WRITE: ctrl = '{wr_en: 1'b1, rd_en: 1'b1, bypass: 1'b1};
            default:            ctrl = '{wr_en: 1'b0, rd_en: 1'b0, bypass: 1'b0};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/dmem_storage_array.sv
// Flop-based storage for data_memory: DEPTH words with asynchronous
// active-low clear, one synchronous write port and one combinational read port.
module dmem_storage_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear every word on reset; otherwise store the write word at its address.
    // NOTE: the whole array is reset here on purpose -- memory must read back
    // as zero after reset, so this cannot map onto a RAM macro without clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read of the addressed word; the top registers it.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM for the load/store stage.
// Synchronous writes, registered reads (one cycle latency, result holds
// until the next read), write-through when both strobes are high.
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] read_data
);

    dmem_op_e              op;
    dmem_ctrl_t            ctrl;
    logic [DATA_WIDTH-1:0] array_rdata;
    logic [DATA_WIDTH-1:0] read_data_d;
    logic [DATA_WIDTH-1:0] read_data_q;

    // Decode the strobes into write enable, read enable and bypass select.
    always_comb begin
        op   = dmem_decode_op(mem_read, mem_write);
        ctrl = dmem_op_ctrl(op);
    end

    dmem_storage_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_storage (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ctrl.wr_en),
        .waddr_i (address),
        .wdata_i (write_data),
        .raddr_i (address),
        .rdata_o (array_rdata)
    );

    // Next read result: hold by default, load stored word or bypassed write data.
    always_comb begin
        // NOTE: default first so no path leaves read_data_d unassigned (no latch).
        read_data_d = read_data_q;
        if (ctrl.rd_en) begin
            read_data_d = ctrl.bypass ? write_data : array_rdata;
        end
    end

    // Read result register; cleared asynchronously, otherwise updated each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by random
// traffic, checked against an array model through an expected-read queue.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [7:0]  address;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] read_data;

    int total;
    int bad;

    logic [15:0] model [256];
    logic [15:0] last_exp;
    logic [15:0] exp_q [$];

    data_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        last_exp = 16'h0000;
    endtask

    // Monitor: a read strobe sampled at an edge yields a result just after it.
    initial begin
        logic        rd;
        logic [15:0] exp;
        forever begin
            @(posedge clk);
            rd = mem_read && rst_n;
            #1;
            if (rd) begin
                if (exp_q.size() == 0) begin
                    check("read_unexpected", read_data, 16'hxxxx);
                end else begin
                    exp = exp_q.pop_front();
                    check("read_data", read_data, exp);
                end
            end
        end
    end

    // One access cycle; inputs are driven 2 time units after a rising edge.
    task automatic access(input logic [7:0] a, input logic [15:0] d,
                          input logic rd, input logic wr);
        logic [15:0] exp;
        address    = a;
        write_data = d;
        mem_read   = rd;
        mem_write  = wr;
        if (wr) model[a] = d;
        if (rd) begin
            exp      = model[a];
            last_exp = exp;
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #2;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        access(a, d, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [7:0] a);
        access(a, $urandom, 1'b1, 1'b0);
    endtask

    // Idle cycles with a wandering address; read_data must keep its value.
    task automatic idle_hold(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            address    = 8'($urandom);
            write_data = 16'($urandom);
            @(posedge clk);
            #2;
            check(name, read_data, last_exp);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        address    = '0;
        write_data = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        model_reset();

        // 1. reset
        #1;
        check("reset_read_data", read_data, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rd(8'h00);
        rd(8'h10);
        rd(8'hFF);

        // 2. write then read, value holds after mem_read falls
        wr(8'h10, 16'hABCD);
        idle_hold(1, "idle_after_write");
        rd(8'h10);
        idle_hold(1, "hold_after_read");

        // 3. boundaries and isolation
        wr(8'h00, 16'h1111);
        wr(8'hFF, 16'hFFFF);
        rd(8'h00);
        rd(8'hFF);
        rd(8'h01);
        rd(8'h10);

        // 4. simultaneous strobes: write-through
        access(8'h20, 16'h5A5A, 1'b1, 1'b1);
        rd(8'h20);

        // 5. hold then overwrite
        idle_hold(3, "hold_idle");
        wr(8'h20, 16'h0F0F);
        rd(8'h20);

        // 6. async reset mid-operation
        address    = 8'h30;
        write_data = 16'hBEEF;
        mem_write  = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", read_data, 16'h0000);
        mem_write = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("after_reset_hold", read_data, 16'h0000);
        rd(8'h30);
        rd(8'h10);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [7:0]  a;
            logic [15:0] d;
            int          sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       a = 8'h00;
                1:       a = 8'hFF;
                2:       a = 8'($urandom_range(0, 7));
                default: a = 8'($urandom);
            endcase
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       idle_hold(1, "rand_hold");
                1:       access(a, d, 1'b0, 1'b1);
                2:       access(a, d, 1'b1, 1'b0);
                default: access(a, d, 1'b1, 1'b1);
            endcase
        end

        idle_hold(1, "final_hold");
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port, word-addressed data RAM for the 8-bit CPU datapath: 256 words x 16 bits.
- Sits behind the load/store stage and is driven by the control unit's mem_read/mem_write strobes.
- Writes are synchronous.
- Reads are registered: one cycle of latency, and the result holds until the next read.

Parameters:
- ADDR_WIDTH, 8, address width in bits; depth DEPTH = 2**ADDR_WIDTH (derived, not overridable).
- DATA_WIDTH, 16, word width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_WIDTH  word address for the read or write.
- write_data  input  DATA_WIDTH  data to store when mem_write=1.
- mem_read  input  1  read strobe, sampled on the rising edge of clk.
- mem_write  input  1  write strobe, sampled on the rising edge of clk.
- read_data  output  DATA_WIDTH  registered read result.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - read_data = 0, immediately on assertion, with no dependence on clk.
  - All DEPTH storage words are cleared to 0.
  - Reset has priority over any strobe in the same cycle.
- Write: at posedge clk with rst_n=1 and mem_write=1, mem[address] <= write_data. No other word changes.
- Read:
  - At posedge clk with rst_n=1 and mem_read=1, read_data <= mem[address].
  - Latency is 1 cycle: data is valid after the edge where mem_read is sampled high.
  - read_data holds its last value while mem_read=0. Deasserting mem_read must not clear it.
- mem_read=0 and mem_write=0: no state change.
- Simultaneous mem_read=1 and mem_write=1 (same address by construction, single port):
  - Write-through: mem[address] <= write_data.
  - read_data <= write_data (new data, not old contents).
- Address range: DEPTH covers the full address space, so there is no out-of-range case. Address 0 and address DEPTH-1 (8'hFF) behave identically to all others.
- Reset mid-operation: a write or read in flight when rst_n falls is discarded. After release, memory reads as 0 and read_data = 0 until the next read.
- Reset deassertion is assumed to be synchronised to clk externally. The first active edge after release performs normal read/write.
- No X-propagation: read_data is never X after reset has been applied once.

Decomposition:
- Shared package dmem_pkg:
  - localparams DMEM_ADDR_WIDTH=8 and DMEM_DATA_WIDTH=16.
  - typedefs dmem_addr_t (logic [7:0]) and dmem_word_t (logic [15:0]).
- The top-level block data_memory holds the read_data register and the strobe decode.
- One sub-module is natural: dmem_storage_array.
  - Contents: DEPTH x DATA_WIDTH flop array with asynchronous active-low clear, write enable, write address/data and a combinational read port.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release; read addresses 8'h00, 8'h10 and 8'hFF -> read_data = 16'h0000 each, one cycle after each read strobe.
2. Write then read: write 16'hABCD at 8'h10 for one cycle, idle one cycle, then assert mem_read at 8'h10 for one cycle and deassert -> read_data = 16'hABCD after the read edge, and it still equals 16'hABCD after mem_read falls.
3. Boundaries and isolation:
   - Write 16'h1111 at 8'h00 and 16'hFFFF at 8'hFF.
   - Read 8'h00, 8'hFF and 8'h01 -> 16'h1111, 16'hFFFF, 16'h0000.
   - Read 8'h10 -> still 16'hABCD.
4. Simultaneous strobes: mem_read=1 and mem_write=1 at 8'h20 with write_data=16'h5A5A -> read_data = 16'h5A5A on that edge; a later read of 8'h20 also returns 16'h5A5A.
5. Hold and overwrite: after reading 16'h5A5A, change address with both strobes low for 3 cycles -> read_data stays 16'h5A5A. Then write 16'h0F0F to 8'h20 and read it -> 16'h0F0F.
6. Async reset mid-operation: with mem_write=1 (8'h30, 16'hBEEF), pulse rst_n low between clock edges -> read_data = 0 immediately; after release, a read of 8'h30 and of 8'h10 both return 16'h0000.
